// File: rtl/riscv_core.sv
// Single-cycle RV32I integer core: fetch, decode, execute and retire one
// instruction per clock against asynchronous-read instruction/data memories.
// Optional retirement trace is compiled in only when RISCV_CORE_TRACE_EN is defined.
module riscv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    output logic        inst_ce_o,
    output logic        data_ce_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        running;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] alu;
    logic        wb_en;
    logic [31:0] wb_val;
    logic        mem_read;
    logic        mem_write;
    logic        taken;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'd0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Decode and execute the current instruction; anything not recognised falls through as a NOP
    always_comb begin
        next_pc   = pc + 32'd4;
        alu       = 32'd0;
        wb_en     = 1'b0;
        wb_val    = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        taken     = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu    = imm_u;
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                alu    = pc + imm_u;
                wb_en  = 1'b1;
                wb_val = alu;
            end
            OP_JAL: begin
                alu     = pc + imm_j;
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = alu;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    alu     = rs1_val + imm_i;
                    wb_en   = 1'b1;
                    wb_val  = pc + 32'd4;
                    next_pc = {alu[31:1], 1'b0};
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  taken = (rs1_val < rs2_val);
                    3'b111:  taken = (rs1_val >= rs2_val);
                    default: taken = 1'b0;
                endcase
                if (taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    alu      = rs1_val + imm_i;
                    mem_read = 1'b1;
                    wb_en    = 1'b1;
                    wb_val   = data_i;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    alu       = rs1_val + imm_s;
                    mem_write = 1'b1;
                end
            end
            OP_IMM: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000: alu = rs1_val + imm_i;
                    3'b010: alu = {31'd0, $signed(rs1_val) < $signed(imm_i)};
                    3'b011: alu = {31'd0, rs1_val < imm_i};
                    3'b100: alu = rs1_val ^ imm_i;
                    3'b110: alu = rs1_val | imm_i;
                    3'b111: alu = rs1_val & imm_i;
                    3'b001: begin
                        if (funct7 == 7'h00) alu = rs1_val << imm_i[4:0];
                        else wb_en = 1'b0;
                    end
                    default: begin
                        if (funct7 == 7'h00) alu = rs1_val >> imm_i[4:0];
                        else if (funct7 == 7'h20) alu = $signed(rs1_val) >>> imm_i[4:0];
                        else wb_en = 1'b0;
                    end
                endcase
                wb_val = alu;
            end
            OP_REG: begin
                if (funct7 == 7'h00) begin
                    wb_en = 1'b1;
                    case (funct3)
                        3'b000:  alu = rs1_val + rs2_val;
                        3'b001:  alu = rs1_val << rs2_val[4:0];
                        3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
                        3'b011:  alu = {31'd0, rs1_val < rs2_val};
                        3'b100:  alu = rs1_val ^ rs2_val;
                        3'b101:  alu = rs1_val >> rs2_val[4:0];
                        3'b110:  alu = rs1_val | rs2_val;
                        default: alu = rs1_val & rs2_val;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    wb_en = 1'b1;
                    alu   = rs1_val - rs2_val;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    wb_en = 1'b1;
                    alu   = $signed(rs1_val) >>> rs2_val[4:0];
                end
                wb_val = alu;
            end
            default: ;
        endcase
    end

    // PC, fetch enable and register-file write; the first edge after reset only enables fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            running <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            pc <= next_pc;
            if (wb_en && rd != 5'd0) begin
                regs[rd] <= wb_val;
            end
        end
    end

    assign inst_addr_o = pc;
    assign inst_ce_o   = running;
    assign data_ce_o   = running & (mem_read | mem_write);
    assign data_we_o   = running & mem_write;
    assign data_addr_o = running ? alu : 32'd0;
    assign data_o      = running ? rs2_val : 32'd0;

`ifdef RISCV_CORE_TRACE_EN
    // Simulation-only retirement trace, one line per executed instruction
    always @(posedge clk) begin
        if (rst && running) begin
            if (mem_write)
                $display("%0t pc=%h inst=%h sw addr=%h data=%h", $time, pc, inst_i, alu, rs2_val);
            else if (mem_read)
                $display("%0t pc=%h inst=%h lw addr=%h val=%h rd=x%0d", $time, pc, inst_i, alu, data_i, rd);
            else if (wb_en && rd != 5'd0)
                $display("%0t pc=%h inst=%h rd=x%0d val=%h", $time, pc, inst_i, rd, wb_val);
            else
                $display("%0t pc=%h inst=%h", $time, pc, inst_i);
        end
    end
`else
    // Trace disabled: only the core logic above is elaborated.
`endif

endmodule

// File: tb/tb_riscv_core.sv
// Self-checking bench for riscv_core: a directed program plus a random program,
// both run in lockstep against an instruction-level reference model.
module tb_riscv_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic        inst_ce_o;
    logic        data_ce_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_i;
    logic [31:0] data_o;

    logic [31:0] imem      [256];
    logic [31:0] dmem      [256];
    logic [31:0] dmem_init [256];
    logic        preload = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [256];

    int checks;
    int errors;

    riscv_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr_o(inst_addr_o),
        .inst_i     (inst_i),
        .inst_ce_o  (inst_ce_o),
        .data_ce_o  (data_ce_o),
        .data_we_o  (data_we_o),
        .data_addr_o(data_addr_o),
        .data_i     (data_i),
        .data_o     (data_o)
    );

    always #5 clk = ~clk;

    assign inst_i = imem[inst_addr_o[9:2]];
    assign data_i = dmem[data_addr_o[9:2]];

    // Data memory: preload image during reset, otherwise capture stores on the rising edge
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
        end else if (data_ce_o && data_we_o) begin
            dmem[data_addr_o[9:2]] <= data_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
    endfunction

    // Reference model: architectural effect of one instruction on m_pc / m_x / m_mem
    task automatic iss_step(input logic [31:0] ins, output bit ld, output bit st,
                            output logic [31:0] ea, output logic [31:0] sd);
        logic [31:0] a, b, ii, is, ib, iu, ij, nxt, val;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  sh;
        bit          wr, t;
        a  = m_x[ins[19:15]];
        b  = m_x[ins[24:20]];
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'h000};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ld = 0; st = 0; ea = 0; sd = 0; wr = 0; t = 0; val = 0; sh = 0;
        nxt = m_pc + 4;
        case (ins[6:0])
            7'h37: begin wr = 1; val = iu; end
            7'h17: begin wr = 1; val = m_pc + iu; end
            7'h6F: begin wr = 1; val = m_pc + 4; nxt = m_pc + ij; end
            7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: t = 0;
                endcase
                if (t) nxt = m_pc + ib;
            end
            7'h03: if (f3 == 2) begin ld = 1; ea = a + ii; wr = 1; val = m_mem[ea[9:2]]; end
            7'h23: if (f3 == 2) begin st = 1; ea = a + is; sd = b; m_mem[ea[9:2]] = b; end
            7'h13: begin
                wr = 1;
                sh = ii[4:0];
                case (f3)
                    3'd0: val = a + ii;
                    3'd2: val = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ ii;
                    3'd6: val = a | ii;
                    3'd7: val = a & ii;
                    3'd1: if (f7 == 0) val = a << sh; else wr = 0;
                    default: begin
                        if (f7 == 0) val = a >> sh;
                        else if (f7 == 7'h20) val = $signed(a) >>> sh;
                        else wr = 0;
                    end
                endcase
            end
            7'h33: begin
                sh = b[4:0];
                if (f7 == 0) begin
                    wr = 1;
                    case (f3)
                        3'd0: val = a + b;
                        3'd1: val = a << sh;
                        3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: val = (a < b) ? 32'd1 : 32'd0;
                        3'd4: val = a ^ b;
                        3'd5: val = a >> sh;
                        3'd6: val = a | b;
                        default: val = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 0) begin
                    wr = 1; val = a - b;
                end else if (f7 == 7'h20 && f3 == 5) begin
                    wr = 1; val = $signed(a) >>> sh;
                end
            end
            default: ;
        endcase
        if (wr && ins[11:7] != 0) m_x[ins[11:7]] = val;
        m_pc = nxt;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce"},   {31'd0, inst_ce_o}, 32'd0);
        chk({tag, "_pc"},   inst_addr_o, 32'd0);
        chk({tag, "_dce"},  {31'd0, data_ce_o}, 32'd0);
        chk({tag, "_dwe"},  {31'd0, data_we_o}, 32'd0);
        chk({tag, "_addr"}, data_addr_o, 32'd0);
        chk({tag, "_data"}, data_o, 32'd0);
    endtask

    // Hold reset three cycles, then release; fetch must stay off until the next edge
    task automatic reset_hold(input bit do_preload);
        rst     = 1'b0;
        preload = do_preload;
        m_pc    = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        if (do_preload) for (int i = 0; i < 256; i++) m_mem[i] = dmem_init[i];
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        preload = 1'b0;
        rst     = 1'b1;
        #1;
        chk("ce_before_edge", {31'd0, inst_ce_o}, 32'd0);
        chk("pc_before_edge", inst_addr_o, 32'd0);
    endtask

    // Lockstep run: compare fetch address and data-side outputs, then advance the model
    task automatic run_cycles(input int n);
        bit          ld, st;
        logic [31:0] ea, sd;
        repeat (n) begin
            @(negedge clk);
            chk("ce_on", {31'd0, inst_ce_o}, 32'd1);
            chk("pc", inst_addr_o, m_pc);
            iss_step(imem[m_pc[9:2]], ld, st, ea, sd);
            chk("data_ce", {31'd0, data_ce_o}, {31'd0, ld | st});
            chk("data_we", {31'd0, data_we_o}, {31'd0, st});
            if (ld || st) chk("data_addr", data_addr_o, ea);
            if (st) chk("data_o", data_o, sd);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem[addr[9:2]] = word;
    endtask

    task automatic load_directed();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        put(32'h00, enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
        put(32'h04, enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd7));
        put(32'h08, enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2));
        put(32'h0C, enc_s(5'd3, 5'd0, 12'h000));
        put(32'h10, enc_j(5'd1, 21'd16));
        put(32'h14, enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'h7FF));
        put(32'h18, enc_b(3'd1, 5'd0, 5'd0, 13'd8));
        put(32'h1C, enc_j(5'd0, 21'h14));
        put(32'h20, enc_b(3'd0, 5'd0, 5'd0, 13'h1FF8));
        put(32'h30, enc_u(7'h37, 5'd4, 20'h80000));
        put(32'h34, enc_i(7'h13, 3'd5, 5'd5, 5'd4, {7'h20, 5'd4}));
        put(32'h38, enc_i(7'h13, 3'd5, 5'd6, 5'd4, {7'h00, 5'd4}));
        put(32'h3C, enc_r(7'h00, 3'd2, 5'd8, 5'd4, 5'd0));
        put(32'h40, enc_r(7'h00, 3'd3, 5'd9, 5'd4, 5'd0));
        put(32'h44, enc_u(7'h37, 5'd11, 20'h00001));
        put(32'h48, enc_i(7'h13, 3'd0, 5'd11, 5'd11, 12'h234));
        put(32'h4C, enc_s(5'd11, 5'd0, 12'h040));
        put(32'h50, enc_i(7'h03, 3'd2, 5'd7, 5'd0, 12'h040));
        put(32'h54, enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd9));
        put(32'h58, enc_s(5'd1, 5'd0, 12'h080));
        put(32'h5C, enc_s(5'd5, 5'd0, 12'h084));
        put(32'h60, enc_s(5'd6, 5'd0, 12'h088));
        put(32'h64, enc_s(5'd8, 5'd0, 12'h08C));
        put(32'h68, enc_s(5'd9, 5'd0, 12'h090));
        put(32'h6C, enc_s(5'd7, 5'd0, 12'h094));
        put(32'h70, enc_s(5'd0, 5'd0, 12'h098));
        put(32'h74, enc_i(7'h67, 3'd0, 5'd1, 5'd1, 12'h069));
        put(32'h78, enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd1));
        put(32'h7C, enc_s(5'd1, 5'd0, 12'h09C));
        put(32'h80, enc_u(7'h17, 5'd13, 20'h00000));
        put(32'h84, enc_s(5'd13, 5'd0, 12'h0A0));
        put(32'h88, enc_j(5'd0, 21'd0));
    endtask

    function automatic logic [31:0] rand_inst(input logic [31:0] addr);
        logic [4:0]  rd, r1, r2, sh;
        logic [2:0]  f3;
        logic [31:0] w;
        int          k;
        rd = 5'($urandom_range(0, 15));
        r1 = 5'($urandom_range(0, 15));
        r2 = 5'($urandom_range(0, 15));
        sh = 5'($urandom_range(0, 31));
        f3 = 3'($urandom_range(0, 7));
        k  = $urandom_range(0, 13);
        w  = $urandom();
        case (k)
            0, 1, 2: begin
                if (f3 == 3'd1) rand_inst = enc_i(7'h13, f3, rd, r1, {7'h00, sh});
                else if (f3 == 3'd5) rand_inst = enc_i(7'h13, f3, rd, r1, {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, sh});
                else rand_inst = enc_i(7'h13, f3, rd, r1, w[11:0]);
            end
            3, 4, 5: rand_inst = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                                       f3, rd, r1, r2);
            6:  rand_inst = enc_u(7'h37, rd, w[19:0]);
            7:  rand_inst = enc_u(7'h17, rd, w[19:0]);
            8:  rand_inst = enc_i(7'h03, 3'd2, rd, 5'd0, 12'($urandom_range(0, 127) * 4));
            9:  rand_inst = enc_s(r2, 5'd0, 12'($urandom_range(0, 127) * 4));
            10: rand_inst = enc_b(3'($urandom_range(0, 7)), r1, r2, 13'd8);
            11: rand_inst = enc_j(rd, 21'd8);
            12: rand_inst = enc_i(7'h67, 3'd0, rd, 5'd0, addr[11:0] + 12'd8);
            default: begin
                case (w[1:0])
                    2'd0:    rand_inst = 32'h0000_000F;
                    2'd1:    rand_inst = 32'h0000_0073;
                    2'd2:    rand_inst = 32'h3000_2573;
                    default: rand_inst = 32'hFFFF_FFFF;
                endcase
            end
        endcase
    endfunction

    // 60 random instructions, then every register x1..x31 stored to 0x204.., then a self-loop
    task automatic load_random();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 60; i++) imem[i] = rand_inst(32'(i * 4));
        for (int r = 1; r < 32; r++) imem[59 + r] = enc_s(5'(r), 5'd0, 12'(32'h200 + r * 4));
        imem[91] = enc_j(5'd0, 21'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #1;
        for (int i = 0; i < 256; i++) dmem_init[i] = $urandom();

        load_directed();
        reset_hold(1'b1);
        run_cycles(40);
        chk("sum_store",  dmem[0],     32'd12);
        chk("sw_lw_mem",  dmem[16],    32'h0000_1234);
        chk("jal_link",   dmem[32],    32'h0000_0014);
        chk("srai",       dmem[33],    32'hF800_0000);
        chk("srli",       dmem[34],    32'h0800_0000);
        chk("slt_neg",    dmem[35],    32'd1);
        chk("sltu_big",   dmem[36],    32'd0);
        chk("lw_value",   dmem[37],    32'h0000_1234);
        chk("x0_zero",    dmem[38],    32'd0);
        chk("jalr_link",  dmem[39],    32'h0000_0078);
        chk("auipc",      dmem[40],    32'h0000_0080);

        for (int i = 0; i < 256; i++) dmem_init[i] = $urandom();
        load_random();
        reset_hold(1'b1);
        run_cycles(25);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        reset_hold(1'b0);
        run_cycles(110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
